flush_sequencer: RTL and testbench

FLUSH_SEQUENCER -- requirements
Module: flush_sequencer

---
 rtl/flush_sequencer.sv | 111 +++++++++++
 tb/tb_flush_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/flush_sequencer.sv
// Control-hazard flush sequencer: turns a jump/branch flush request into a one-cycle
// PC redirect plus a train of pipeline-register clears, waiting out a busy instruction memory.
module flush_sequencer #(
    parameter int SQUASH_DEPTH = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [31:0]      target_pc,
    input  logic             imem_busy,
    input  logic             stall,
    output logic             pc_sel,
    output logic [31:0]      pc_redirect,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             pc_hold,
    output logic             busy,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    localparam logic [2:0]       SQ_LOAD = 3'(SQUASH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [2:0]  sq_cnt;
    logic [31:0] target_q;

    assign dbg_state = state;

    // Handshake: flush is a request with no ready back; it is accepted only when the
    // sequencer is IDLE and silently dropped otherwise (the requester is younger and squashed).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sq_cnt      <= 3'd0;
            target_q    <= 32'h0;
            pc_sel      <= 1'b0;
            pc_redirect <= 32'h0;
            ifid_clr    <= 1'b0;
            idex_clr    <= 1'b0;
            pc_hold     <= 1'b0;
            busy        <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            pc_sel <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        target_q <= target_pc;
                        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
                        ifid_clr <= 1'b1;
                        idex_clr <= 1'b1;
                        busy     <= 1'b1;
                        if (!imem_busy) begin
                            state       <= SQUASH;
                            pc_sel      <= 1'b1;
                            pc_redirect <= target_pc;
                            pc_hold     <= 1'b0;
                            sq_cnt      <= SQ_LOAD;
                        end else begin
                            state   <= WAIT_MEM;
                            pc_hold <= 1'b1;
                        end
                    end else begin
                        // load-use bubble: hold fetch, kill only the ID/EX slot
                        ifid_clr <= 1'b0;
                        idex_clr <= stall;
                        pc_hold  <= stall;
                        busy     <= 1'b0;
                    end
                end
                WAIT_MEM: begin
                    if (!imem_busy) begin
                        state       <= SQUASH;
                        pc_sel      <= 1'b1;
                        pc_redirect <= target_q;
                        pc_hold     <= 1'b0;
                        sq_cnt      <= SQ_LOAD;
                    end
                end
                SQUASH: begin
                    // sq_cnt counts the clear cycles left after the current one
                    if (sq_cnt != 3'd0) begin
                        sq_cnt <= sq_cnt - 3'd1;
                    end else begin
                        state    <= IDLE;
                        ifid_clr <= 1'b0;
                        idex_clr <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ifid_clr <= 1'b0;
                    idex_clr <= 1'b0;
                    pc_hold  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flush_sequencer.sv
// Bench for flush_sequencer: two instances (depth 2 / 16-bit count, depth 1 / 4-bit count)
// compared every cycle against a cycle-count reference model.
module tb_flush_sequencer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] target_pc;
    logic        imem_busy;
    logic        stall;

    logic        sel0, ifid0, idex0, hold0, busy0;
    logic [31:0] red0;
    logic [15:0] cnt0;
    logic [1:0]  st0;
    logic        sel1, ifid1, idex1, hold1, busy1;
    logic [31:0] red1;
    logic [3:0]  cnt1;
    logic [1:0]  st1;

    flush_sequencer #(.SQUASH_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .target_pc(target_pc),
        .imem_busy(imem_busy), .stall(stall), .pc_sel(sel0), .pc_redirect(red0),
        .ifid_clr(ifid0), .idex_clr(idex0), .pc_hold(hold0), .busy(busy0),
        .flush_cnt(cnt0), .dbg_state(st0)
    );

    flush_sequencer #(.SQUASH_DEPTH(1), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .flush(flush), .target_pc(target_pc),
        .imem_busy(imem_busy), .stall(stall), .pc_sel(sel1), .pc_redirect(red1),
        .ifid_clr(ifid1), .idex_clr(idex1), .pc_hold(hold1), .busy(busy1),
        .flush_cnt(cnt1), .dbg_state(st1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: sl = clear cycles still owed, pend = redirect waiting for memory
    int          depth [2] = '{2, 1};
    int          max_cnt [2] = '{65535, 15};
    int          sl [2];
    bit          pend [2];
    int          cnt [2];
    logic [31:0] tgt [2];
    bit          e_sel [2], e_ifid [2], e_idex [2], e_hold [2], e_busy [2];
    logic [31:0] exp_q[$];
    logic [31:0] exp_q_small[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sl[i] = 0; pend[i] = 0; cnt[i] = 0; tgt[i] = 32'h0;
            e_sel[i] = 0; e_ifid[i] = 0; e_idex[i] = 0; e_hold[i] = 0; e_busy[i] = 0;
        end
        exp_q.delete();
        exp_q_small.delete();
    endtask

    task automatic push_exp(input int i, input logic [31:0] t);
        if (i == 0) exp_q.push_back(t);
        else        exp_q_small.push_back(t);
    endtask

    task automatic model_step(input bit f, input logic [31:0] t, input bit mb, input bit st);
        for (int i = 0; i < 2; i++) begin
            bit bubble;
            bubble = 0;
            e_sel[i] = 0;
            if (sl[i] > 0) begin
                sl[i]--;
            end else if (pend[i]) begin
                if (!mb) begin
                    pend[i] = 0; sl[i] = depth[i]; e_sel[i] = 1; push_exp(i, tgt[i]);
                end
            end else if (f) begin
                if (cnt[i] < max_cnt[i]) cnt[i]++;
                tgt[i] = t;
                if (!mb) begin
                    sl[i] = depth[i]; e_sel[i] = 1; push_exp(i, t);
                end else begin
                    pend[i] = 1;
                end
            end else if (st) begin
                bubble = 1;
            end
            e_busy[i] = pend[i] || (sl[i] > 0);
            e_ifid[i] = e_busy[i];
            e_idex[i] = e_busy[i] || bubble;
            e_hold[i] = pend[i] || bubble;
        end
    endtask

    task automatic compare_outs(input int i, input logic sel, input logic [31:0] red,
                                input logic ifid, input logic idex, input logic hold,
                                input logic bsy, input logic [15:0] c);
        string p;
        logic [31:0] exp_red;
        p = (i == 0) ? "d2" : "d1";
        check({p, "_pc_sel"}, 32'(sel), 32'(e_sel[i]));
        check({p, "_ifid_clr"}, 32'(ifid), 32'(e_ifid[i]));
        check({p, "_idex_clr"}, 32'(idex), 32'(e_idex[i]));
        check({p, "_pc_hold"}, 32'(hold), 32'(e_hold[i]));
        check({p, "_busy"}, 32'(bsy), 32'(e_busy[i]));
        check({p, "_flush_cnt"}, 32'(c), 32'(cnt[i]));
        if (e_sel[i]) begin
            if (i == 0) exp_red = exp_q.pop_front();
            else        exp_red = exp_q_small.pop_front();
            check({p, "_pc_redirect"}, red, exp_red);
        end
    endtask

    task automatic compare_all();
        compare_outs(0, sel0, red0, ifid0, idex0, hold0, busy0, cnt0);
        compare_outs(1, sel1, red1, ifid1, idex1, hold1, busy1, {12'h0, cnt1});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pc_sel"}, 32'({sel0, sel1}), 32'h0);
        check({tag, "_redirect0"}, red0, 32'h0);
        check({tag, "_redirect1"}, red1, 32'h0);
        check({tag, "_clr"}, 32'({ifid0, idex0, ifid1, idex1}), 32'h0);
        check({tag, "_hold_busy"}, 32'({hold0, busy0, hold1, busy1}), 32'h0);
        check({tag, "_cnt0"}, 32'(cnt0), 32'h0);
        check({tag, "_cnt1"}, 32'(cnt1), 32'h0);
    endtask

    // driver: called at a falling edge, applies inputs for one rising edge, checks at the next fall
    task automatic cycle(input bit f, input logic [31:0] t, input bit mb, input bit st);
        flush = f; target_pc = t; imem_busy = mb; stall = st;
        @(posedge clk);
        model_step(f, t, mb, st);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(0, 32'h0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; target_pc = 32'h0; imem_busy = 1'b0; stall = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        idle_cycles(2);

        // plain redirect to 0x40
        cycle(1, 32'h40, 0, 0);
        idle_cycles(3);

        // flush during PC_SEL cycle is ignored
        cycle(1, 32'h40, 0, 0);
        cycle(1, 32'h200, 0, 0);
        idle_cycles(3);

        // memory busy for three edges, then redirect to 0x100; late flushes ignored
        cycle(1, 32'h100, 1, 0);
        cycle(1, 32'h300, 1, 0);
        cycle(0, 32'h0, 1, 0);
        cycle(0, 32'h0, 0, 0);
        idle_cycles(3);

        // flush beats stall, then a bare two-cycle stall
        cycle(1, 32'h80, 0, 1);
        cycle(0, 32'h0, 0, 1);
        cycle(0, 32'h0, 0, 1);
        idle_cycles(2);
        cycle(0, 32'h0, 0, 1);
        cycle(0, 32'h0, 0, 1);
        idle_cycles(2);

        // asynchronous reset in the middle of a squash
        cycle(1, 32'hABC0, 0, 0);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        #1 reset = 1'b0;
        idle_cycles(4);

        // asynchronous reset while waiting for memory
        cycle(1, 32'h500, 1, 0);
        #2 reset = 1'b1;
        #1 check_zero("reset_wait");
        model_reset();
        #1 reset = 1'b0;
        idle_cycles(3);

        // saturation: steady flush gives the depth-1 instance one accept every other edge
        for (int k = 0; k < 40; k++) cycle(1, 32'(k * 4), 0, 0);
        idle_cycles(3);
        check("cnt_saturated", 32'(cnt1), 32'd15);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 3) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end
        idle_cycles(4);
        check("sb_empty", 32'(exp_q.size() + exp_q_small.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
